// File: rtl/water_dispenser_pkg.sv
// Shared state encoding and default sizing for the metered water dispenser.
package water_dispenser_pkg;

  localparam int unsigned DefaultSwitchCount  = 10;
  localparam int unsigned DefaultAmountWidth  = 8;
  localparam int unsigned DefaultMaxAmount    = 255;
  localparam int unsigned DefaultTicksPerUnit = 4;

  typedef enum logic [1:0] {
    StIdle,
    StAccumulate,
    StDispense,
    StDone
  } state_t;

endpackage

// File: rtl/button_edge_detector.sv
// One sync flop plus one history flop; emits a single-cycle pulse per press.
module button_edge_detector #(
  parameter bit ActiveLow = 1'b0
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic button_i,
  output logic press_o
);

  localparam logic IdleLevel = ActiveLow;

  logic sync_q;
  logic prev_q;
  logic armed_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q  <= IdleLevel;
      prev_q  <= IdleLevel;
      armed_q <= 1'b0;
    end else begin
      sync_q  <= button_i;
      prev_q  <= sync_q;
      // A button held active through reset release must return to idle before it can fire.
      armed_q <= armed_q | (button_i == IdleLevel);
    end
  end

  assign press_o = armed_q & (prev_q == IdleLevel) & (sync_q != IdleLevel);

endmodule

// File: rtl/metered_water_dispenser.sv
// Accumulates a requested amount from switch presses, then opens the valve for a metered time.
module metered_water_dispenser
  import water_dispenser_pkg::*;
#(
  parameter int unsigned SWITCH_COUNT   = DefaultSwitchCount,
  parameter int unsigned AMOUNT_WIDTH   = DefaultAmountWidth,
  parameter int unsigned MAX_AMOUNT     = DefaultMaxAmount,
  parameter int unsigned TICKS_PER_UNIT = DefaultTicksPerUnit
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [SWITCH_COUNT-1:0] switches,
  input  logic                    button_add,
  input  logic                    button_ok,
  input  logic                    button_cancel,
  output logic [AMOUNT_WIDTH-1:0] total_amount,
  output logic [AMOUNT_WIDTH-1:0] dispensed_amount,
  output logic                    valve_open,
  output logic                    busy,
  output logic                    overflow
);

  localparam int unsigned TickWidth = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
  localparam logic [TickWidth-1:0]    TickLast = TickWidth'(TICKS_PER_UNIT - 1);
  localparam logic [AMOUNT_WIDTH-1:0] MaxTotal = AMOUNT_WIDTH'(MAX_AMOUNT);
  localparam logic [AMOUNT_WIDTH:0]   MaxSum   = (AMOUNT_WIDTH + 1)'(MAX_AMOUNT);

  logic add_evt;
  logic ok_evt;
  logic cancel_evt;

  button_edge_detector #(.ActiveLow(1'b1)) u_add (
    .clk_i   (clock),
    .reset_i (reset),
    .button_i(button_add),
    .press_o (add_evt)
  );

  button_edge_detector #(.ActiveLow(1'b0)) u_ok (
    .clk_i   (clock),
    .reset_i (reset),
    .button_i(button_ok),
    .press_o (ok_evt)
  );

  button_edge_detector #(.ActiveLow(1'b0)) u_cancel (
    .clk_i   (clock),
    .reset_i (reset),
    .button_i(button_cancel),
    .press_o (cancel_evt)
  );

  state_t                  state_q, state_d;
  logic [AMOUNT_WIDTH-1:0] total_q, total_d;
  logic [AMOUNT_WIDTH-1:0] disp_q, disp_d;
  logic [TickWidth-1:0]    tick_q, tick_d;
  logic                    ovf_q, ovf_d;

  logic [AMOUNT_WIDTH-1:0] sel_amount;
  logic [AMOUNT_WIDTH:0]   sum;

  // Highest set switch wins; later iterations overwrite lower indices.
  always_comb begin
    sel_amount = '0;
    for (int i = 0; i < SWITCH_COUNT; i++) begin
      if (switches[i]) sel_amount = AMOUNT_WIDTH'(i);
    end
  end

  assign sum = {1'b0, total_q} + {1'b0, sel_amount};

  always_comb begin
    state_d = state_q;
    total_d = total_q;
    disp_d  = disp_q;
    tick_d  = tick_q;
    ovf_d   = ovf_q;
    if (cancel_evt) begin
      state_d = StIdle;
      total_d = '0;
      tick_d  = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        StIdle, StAccumulate: begin
          if (ok_evt) begin
            // A simultaneous add is dropped even when the ok itself is ignored.
            if (state_q == StAccumulate && total_q != '0) begin
              state_d = StDispense;
              disp_d  = '0;
              tick_d  = '0;
            end
          end else if (add_evt) begin
            state_d = StAccumulate;
            if (sum > MaxSum) begin
              total_d = MaxTotal;
              ovf_d   = 1'b1;
            end else begin
              total_d = sum[AMOUNT_WIDTH-1:0];
            end
          end
        end
        StDispense: begin
          if (tick_q == TickLast) begin
            tick_d  = '0;
            total_d = total_q - AMOUNT_WIDTH'(1);
            disp_d  = disp_q + AMOUNT_WIDTH'(1);
            if (total_q == AMOUNT_WIDTH'(1)) state_d = StDone;
          end else begin
            tick_d = tick_q + TickWidth'(1);
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      total_q <= '0;
      disp_q  <= '0;
      tick_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      total_q <= total_d;
      disp_q  <= disp_d;
      tick_q  <= tick_d;
      ovf_q   <= ovf_d;
    end
  end

  assign total_amount     = total_q;
  assign dispensed_amount = disp_q;
  assign valve_open       = (state_q == StDispense);
  assign busy             = (state_q == StDispense) || (state_q == StDone);
  assign overflow         = ovf_q;

endmodule

// File: tb/tb_metered_water_dispenser.sv
// Scoreboard bench: stimulus queues expected snapshots, a negedge monitor compares them.
module tb_metered_water_dispenser;
  import water_dispenser_pkg::*;

  logic       clock;
  logic       reset;
  logic [9:0] switches;
  logic       button_add;
  logic       button_ok;
  logic       button_cancel;

  logic [7:0] total_amount, dispensed_amount;
  logic       valve_open, busy, overflow;
  logic [7:0] s_total, s_disp;
  logic       s_valve, s_busy, s_ovf;

  metered_water_dispenser dut (
    .clock           (clock),
    .reset           (reset),
    .switches        (switches),
    .button_add      (button_add),
    .button_ok       (button_ok),
    .button_cancel   (button_cancel),
    .total_amount    (total_amount),
    .dispensed_amount(dispensed_amount),
    .valve_open      (valve_open),
    .busy            (busy),
    .overflow        (overflow)
  );

  metered_water_dispenser #(.MAX_AMOUNT(20)) dut_sat (
    .clock           (clock),
    .reset           (reset),
    .switches        (switches),
    .button_add      (button_add),
    .button_ok       (button_ok),
    .button_cancel   (button_cancel),
    .total_amount    (s_total),
    .dispensed_amount(s_disp),
    .valve_open      (s_valve),
    .busy            (s_busy),
    .overflow        (s_ovf)
  );

  typedef struct {
    string name;
    int    inst;
    int    total;
    int    disp;
    int    valve;
    int    busy;
    int    ovf;
    int    st;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  // Monitor: compares every queued snapshot against the DUT at the falling edge.
  always @(negedge clock) begin : mon
    exp_t e;
    int   a_tot, a_disp, a_valve, a_busy, a_ovf, a_st;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.inst == 0) begin
        a_tot = int'(total_amount); a_disp = int'(dispensed_amount);
        a_valve = int'(valve_open); a_busy = int'(busy); a_ovf = int'(overflow);
        a_st = int'(dut.state_q);
      end else begin
        a_tot = int'(s_total); a_disp = int'(s_disp);
        a_valve = int'(s_valve); a_busy = int'(s_busy); a_ovf = int'(s_ovf);
        a_st = int'(dut_sat.state_q);
      end
      n_checks++;
      if (a_tot != e.total || a_disp != e.disp || a_valve != e.valve || a_busy != e.busy ||
          a_ovf != e.ovf || a_st != e.st) begin
        n_fails++;
        $display("FAIL %s: actual tot=%0d disp=%0d valve=%0d busy=%0d ovf=%0d st=%0d required tot=%0d disp=%0d valve=%0d busy=%0d ovf=%0d st=%0d",
                 e.name, a_tot, a_disp, a_valve, a_busy, a_ovf, a_st,
                 e.total, e.disp, e.valve, e.busy, e.ovf, e.st);
      end
    end
  end

  task automatic expect_state(input string name, input int inst, input int total, input int disp,
                              input int valve, input int bsy, input int ovf, input state_t st);
    exp_t e;
    e.name = name; e.inst = inst; e.total = total; e.disp = disp;
    e.valve = valve; e.busy = bsy; e.ovf = ovf; e.st = int'(st);
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic press_add(input int idx);
    switches = '0;
    switches[idx] = 1'b1;
    button_add = 1'b0;
    tick(2);
    button_add = 1'b1;
    tick(2);
  endtask

  task automatic press_ok();
    button_ok = 1'b1;
    tick(2);
    button_ok = 1'b0;
  endtask

  task automatic press_cancel();
    button_cancel = 1'b1;
    tick(2);
    button_cancel = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b1; switches = '0;
    button_add = 1'b1; button_ok = 1'b0; button_cancel = 1'b0;
    tick(2);
    reset = 1'b0;
    expect_state("reset", 0, 0, 0, 0, 0, 0, StIdle);
    tick(2);

    // Accumulate 1 + 9 + 9 + 3.
    press_add(1); expect_state("add1", 0, 1, 0, 0, 0, 0, StAccumulate);
    press_add(9); expect_state("add9a", 0, 10, 0, 0, 0, 0, StAccumulate);
    press_add(9); expect_state("add9b", 0, 19, 0, 0, 0, 0, StAccumulate);
    press_add(3); expect_state("add3", 0, 22, 0, 0, 0, 0, StAccumulate);

    // Dispense 22 units at 4 cycles each.
    press_ok();
    n = 0;
    while (valve_open && n < 200) begin
      n++;
      tick(1);
    end
    n_checks++;
    if (n != 88) begin
      n_fails++;
      $display("FAIL valve_cycles: actual=%0d required=88", n);
    end
    expect_state("done", 0, 0, 22, 0, 1, 0, StDone);
    tick(1);
    expect_state("idle_after_done", 0, 0, 22, 0, 0, 0, StIdle);

    // Held add with two switches: one event, highest index wins.
    switches = '0; switches[3] = 1'b1; switches[5] = 1'b1;
    button_add = 1'b0;
    tick(12);
    button_add = 1'b1;
    tick(2);
    expect_state("held_add", 0, 5, 22, 0, 0, 0, StAccumulate);
    press_cancel();
    expect_state("cancel_accum", 0, 0, 22, 0, 0, 0, StIdle);

    // Saturation on the MAX_AMOUNT=20 instance.
    press_add(9); expect_state("sat9", 1, 9, 20, 0, 0, 0, StAccumulate);
    press_add(9); expect_state("sat18", 1, 18, 20, 0, 0, 0, StAccumulate);
    press_add(9); expect_state("sat20", 1, 20, 20, 0, 0, 1, StAccumulate);
    press_cancel();
    expect_state("sat_cancel", 1, 0, 20, 0, 0, 0, StIdle);
    expect_state("nosat_cancel", 0, 0, 22, 0, 0, 0, StIdle);

    // Cancel with simultaneous ok after three units.
    press_add(9);
    expect_state("add9_run", 0, 9, 22, 0, 0, 0, StAccumulate);
    press_ok();
    tick(11);
    button_cancel = 1'b1; button_ok = 1'b1;
    tick(1);
    expect_state("three_units", 0, 6, 3, 1, 1, 0, StDispense);
    tick(1);
    expect_state("cancel_dispense", 0, 0, 3, 0, 0, 0, StIdle);
    button_cancel = 1'b0; button_ok = 1'b0;
    tick(3);
    expect_state("ok_ignored", 0, 0, 3, 0, 0, 0, StIdle);

    // Reset mid-dispense with add held low through release.
    press_add(9);
    press_ok();
    tick(5);
    switches = '0; switches[2] = 1'b1;
    button_add = 1'b0;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    expect_state("reset_mid", 0, 0, 0, 0, 0, 0, StIdle);
    expect_state("reset_mid_sat", 1, 0, 0, 0, 0, 0, StIdle);
    tick(4);
    expect_state("held_no_add", 0, 0, 0, 0, 0, 0, StIdle);
    button_add = 1'b1;
    tick(2);
    button_add = 1'b0;
    tick(2);
    button_add = 1'b1;
    tick(2);
    expect_state("rearmed_add", 0, 2, 0, 0, 0, 0, StAccumulate);

    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/metered_water_dispenser.md
METERED_WATER_DISPENSER -- requirements
Module: metered_water_dispenser

Interface
REQ-001 SHALL have parameter SWITCH_COUNT, default 10: number of amount-select switches; switch i selects amount i.
REQ-002 SHALL have parameter AMOUNT_WIDTH, default 8: width of all amount counters and outputs.
REQ-003 SHALL have parameter MAX_AMOUNT, default 255: saturation ceiling of the accumulated total; must be <= 2**AMOUNT_WIDTH-1.
REQ-004 SHALL have parameter TICKS_PER_UNIT, default 4: clock cycles the valve stays open per dispensed unit; must be >= 1.
REQ-005 SHALL have the port clock, input, 1 bit: single clock; all logic on its rising edge.
REQ-006 SHALL have the port reset, input, 1 bit: reset is synchronous and active-high.
REQ-007 SHALL have the port switches, input, SWITCH_COUNT bits: amount selection, active-high.
REQ-008 SHALL have the port button_add, input, 1 bit: add request, active-low (idle 1).
REQ-009 SHALL have the port button_ok, input, 1 bit: start dispensing, active-high.
REQ-010 SHALL have the port button_cancel, input, 1 bit: abort and clear, active-high.
REQ-011 SHALL have the port total_amount, output, AMOUNT_WIDTH bits: accumulated amount still to dispense.
REQ-012 SHALL have the port dispensed_amount, output, AMOUNT_WIDTH bits: units dispensed in the current or last run.
REQ-013 SHALL have the port valve_open, output, 1 bit: high only in DISPENSE.
REQ-014 SHALL have the port busy, output, 1 bit: high in DISPENSE and DONE.
REQ-015 SHALL have the port overflow, output, 1 bit: sticky; set when an add saturates.

Function
REQ-016 SHALL register all three buttons through one flop stage, then detect press edges (add: 1->0; ok, cancel: 0->1) against a second flop; each physical press yields exactly one event.
REQ-017 SHALL update outputs on the second rising edge after a button input changes (one sync stage plus one edge stage).
REQ-018 SHALL implement states IDLE, ACCUMULATE, DISPENSE, DONE.
REQ-019 Add event in IDLE or ACCUMULATE SHALL add the index of the highest set switch to total_amount, with 0 added when no switch is set, and SHALL move to ACCUMULATE.
REQ-020 Addition SHALL saturate at MAX_AMOUNT; if the unsaturated sum exceeds MAX_AMOUNT, overflow SHALL be set and held until cancel or reset.
REQ-021 Ok event in ACCUMULATE with total_amount > 0 SHALL enter DISPENSE, clear dispensed_amount and the tick counter; with total_amount == 0 it SHALL be ignored.
REQ-022 In DISPENSE, every TICKS_PER_UNIT cycles total_amount SHALL decrement by 1 and dispensed_amount SHALL increment by 1.
REQ-023 When total_amount reaches 0, the FSM SHALL enter DONE on that edge, close the valve, hold DONE exactly one cycle, then go to IDLE; dispensed_amount SHALL be held until the next ok.
REQ-024 Add and ok events in DISPENSE or DONE SHALL be ignored and not queued.
REQ-025 Cancel event in any state SHALL, on the same edge, go to IDLE, clear total_amount, the tick counter and overflow, and drop valve_open; dispensed_amount SHALL keep its value.
REQ-026 Cancel SHALL take priority over a simultaneous add or ok; ok SHALL take priority over a simultaneous add, which is dropped.

Reset
REQ-027 Reset SHALL force IDLE, clear total_amount, dispensed_amount, the tick counter, overflow, valve_open, busy, and set the add sync/edge flops to 1 and the ok/cancel flops to 0, so no spurious event occurs after reset.
REQ-028 Reset SHALL override every event in the same cycle, including mid-dispense.

Structure
REQ-029 A shared package water_dispenser_pkg SHALL hold the state enum and the default parameter constants.
REQ-030 One sub-module, button_edge_detector (parameterised polarity, one instance per button), SHALL perform the sync and edge detection.

Verification (defaults unless noted)
REQ-031 Add with switches[1], [9], [9], [3] in turn -> total_amount 22, state ACCUMULATE, overflow 0.
REQ-032 Total 22, ok pulse -> valve_open high for exactly 88 cycles, dispensed_amount 22, one DONE cycle, then IDLE with total_amount 0.
REQ-033 switches[3] and [5] both high, add held low 12 cycles -> exactly one add, total increments by 5.
REQ-034 MAX_AMOUNT=20: add 9 three times -> total_amount 20, overflow 1; cancel -> total 0, overflow 0.
REQ-035 Dispensing 9 units, cancel after 3 units -> valve_open low on the cancel edge, total_amount 0, dispensed_amount 3; a simultaneous ok is ignored.
REQ-036 Reset asserted mid-dispense, with button_add held low through reset release -> all outputs 0, IDLE, no add event until button_add returns high and goes low again.
